// File: rtl/comp_sched_pkg.sv
// comp_sched_pkg: shared types and constants for the compression-unit job
// scheduler.
//   state_t        : scheduler FSM states
//   DC_ENC/DC_DEC  : op-select bit positions inside a 24-bit descriptor
//   CAP_ENC/CAP_DEC: matching bit positions inside the datapath capability mask
//   op_ok()        : true when a descriptor selects exactly one op and the
//                    datapath advertises that op
package comp_sched_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RST,
      ST_RUN,
      ST_ABORT,
      ST_DONE
   } state_t;

   localparam int DC_W    = 24;
   localparam int CAP_W   = 8;
   localparam int DC_ENC  = 5;
   localparam int DC_DEC  = 6;
   localparam int CAP_ENC = 5;
   localparam int CAP_DEC = 6;

   function automatic logic op_ok(input logic [DC_W-1:0] dc, input logic [CAP_W-1:0] cap);
      logic one_hot;
      logic supported;
      one_hot   = dc[DC_ENC] ^ dc[DC_DEC];
      supported = (dc[DC_ENC] & cap[CAP_ENC]) | (dc[DC_DEC] & cap[CAP_DEC]);
      return one_hot & supported;
   endfunction

endpackage

// File: rtl/comp_sched_rr_arb2.sv
// rr_arb2: two-way round-robin arbiter.
//   clk     in  : clock
//   rst_n   in  : synchronous active-low reset
//   req     in 2: request vector
//   advance in  : record the current grant as the last-served requester
//   gnt     out 2: one-hot grant (combinational from req and the pointer)
// The pointer resets to "requester 1 served last" so requester 0 wins the
// first contested grant.
module rr_arb2 (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] req,
   input  logic       advance,
   output logic [1:0] gnt
);

   logic last_reg;   // 1: requester 1 was served last

   always_comb begin
      gnt = req;
      if (req == 2'b11) begin
         gnt = last_reg ? 2'b01 : 2'b10;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         last_reg <= 1'b1;
      end else if (advance && (gnt != 2'b00)) begin
         last_reg <= gnt[1];
      end
   end

endmodule

// File: rtl/comp_sched.sv
// comp_sched: job scheduler in front of the compression datapath.
// Arbitrates two requesters round-robin, checks the requested op against the
// datapath capability mask, then sequences reset pulse, enable window, end
// detection and timeout abort, and reports per-requester completion/error.
// Ports:
//   wb_clk_i, wb_rst_n      : clock, synchronous active-low reset
//   req_i[1:0]              : level job requests, held until ack_o
//   req_dc0_i, req_dc1_i    : 24-bit descriptors for requester 0/1
//   timeout_cyc_i           : max RUN cycles (0 = no timeout), sampled at grant
//   ack_o, done_o, err_o    : one-cycle one-hot pulses per requester
//   busy_o                  : scheduler not idle
//   m_reset, m_enable, m_dc : datapath control and descriptor
//   m_endn, m_cap           : datapath end (active-low) and capability mask
// All outputs are registered.
module comp_sched
   import comp_sched_pkg::*;
#(
   parameter int RST_CYC = 4,
   parameter int TO_W    = 20
) (
   input  logic              wb_clk_i,
   input  logic              wb_rst_n,
   input  logic [1:0]        req_i,
   input  logic [DC_W-1:0]   req_dc0_i,
   input  logic [DC_W-1:0]   req_dc1_i,
   input  logic [TO_W-1:0]   timeout_cyc_i,
   output logic [1:0]        ack_o,
   output logic [1:0]        done_o,
   output logic [1:0]        err_o,
   output logic              busy_o,
   output logic              m_reset,
   output logic              m_enable,
   output logic [DC_W-1:0]   m_dc,
   input  logic              m_endn,
   input  logic [CAP_W-1:0]  m_cap
);

   localparam int RC_W = 4;
   localparam logic [RC_W-1:0] RC_LAST = RC_W'(RST_CYC - 1);
   localparam logic [TO_W-1:0] TO_ONE  = TO_W'(1);

   state_t            state_reg;
   logic [RC_W-1:0]   rst_cnt_reg;
   logic [TO_W-1:0]   to_cnt_reg;
   logic [TO_W-1:0]   to_lim_reg;
   logic [1:0]        owner_reg;
   logic              rej_reg;     // rejected job waiting for its done pulse

   logic [1:0]        gnt;
   logic [DC_W-1:0]   gnt_dc;
   logic              advance;
   logic              rst_last;
   logic [TO_W-1:0]   to_inc;

   // The pointer moves at grant time; the next grant cannot happen before
   // DONE has returned to IDLE, so this is equivalent to updating it in DONE.
   assign advance  = (state_reg == ST_IDLE);
   assign gnt_dc   = gnt[1] ? req_dc1_i : req_dc0_i;
   assign rst_last = (rst_cnt_reg == RC_LAST);
   // Saturating increment so a huge timeout never sees a wrapped count.
   assign to_inc   = (&to_cnt_reg) ? to_cnt_reg : to_cnt_reg + TO_ONE;

   rr_arb2 u_arb (
      .clk     (wb_clk_i),
      .rst_n   (wb_rst_n),
      .req     (req_i),
      .advance (advance),
      .gnt     (gnt)
   );

   always_ff @(posedge wb_clk_i) begin
      if (!wb_rst_n) begin
         state_reg   <= ST_IDLE;
         ack_o       <= 2'b00;
         done_o      <= 2'b00;
         err_o       <= 2'b00;
         busy_o      <= 1'b0;
         m_reset     <= 1'b1;   // keeps the datapath flushed while in reset
         m_enable    <= 1'b0;
         m_dc        <= '0;
         rst_cnt_reg <= '0;
         to_cnt_reg  <= '0;
         to_lim_reg  <= '0;
         owner_reg   <= 2'b00;
         rej_reg     <= 1'b0;
      end else begin
         ack_o  <= 2'b00;
         done_o <= 2'b00;
         err_o  <= 2'b00;
         case (state_reg)
            ST_IDLE: begin
               m_reset  <= 1'b0;
               m_enable <= 1'b0;
               if (gnt != 2'b00) begin
                  ack_o       <= gnt;
                  owner_reg   <= gnt;
                  busy_o      <= 1'b1;
                  m_dc        <= gnt_dc;
                  to_lim_reg  <= timeout_cyc_i;
                  rst_cnt_reg <= '0;
                  if (op_ok(gnt_dc, m_cap)) begin
                     state_reg <= ST_RST;
                     m_reset   <= 1'b1;
                     rej_reg   <= 1'b0;
                  end else begin
                     // Datapath untouched; DONE issues the error pulse.
                     state_reg <= ST_DONE;
                     rej_reg   <= 1'b1;
                  end
               end
            end
            ST_RST: begin
               if (rst_last) begin
                  state_reg  <= ST_RUN;
                  m_reset    <= 1'b0;
                  m_enable   <= 1'b1;
                  to_cnt_reg <= '0;
               end else begin
                  rst_cnt_reg <= rst_cnt_reg + 1'b1;
               end
            end
            ST_RUN: begin
               // End takes priority over a coincident timeout.
               if (!m_endn) begin
                  state_reg <= ST_DONE;
                  m_enable  <= 1'b0;
                  done_o    <= owner_reg;
               end else if ((to_lim_reg != '0) && (to_inc == to_lim_reg)) begin
                  state_reg   <= ST_ABORT;
                  m_enable    <= 1'b0;
                  m_reset     <= 1'b1;
                  rst_cnt_reg <= '0;
               end else begin
                  to_cnt_reg <= to_inc;
               end
            end
            ST_ABORT: begin
               if (rst_last) begin
                  state_reg <= ST_DONE;
                  m_reset   <= 1'b0;
                  done_o    <= owner_reg;
                  err_o     <= owner_reg;
               end else begin
                  rst_cnt_reg <= rst_cnt_reg + 1'b1;
               end
            end
            ST_DONE: begin
               if (rej_reg) begin
                  rej_reg <= 1'b0;
                  done_o  <= owner_reg;
                  err_o   <= owner_reg;
               end else begin
                  state_reg <= ST_IDLE;
                  busy_o    <= 1'b0;
                  m_dc      <= '0;
                  owner_reg <= 2'b00;
               end
            end
            default: begin
               state_reg <= ST_IDLE;
            end
         endcase
      end
   end

endmodule
